// File: rtl/mix_round_sched.sv
// Shared iterative 8-word add/chain mixer with two round-robin requesters and one valid/ready response port.
// Optional `define MIX_ABORT_EN adds an abort input that drops the job in flight without producing a response.
module mix_round_sched #(
    parameter int WORD_W   = 32,
    parameter int ROUNDS_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*WORD_W-1:0]   req0_seed,
    input  logic [ROUNDS_W-1:0]   req0_rounds,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*WORD_W-1:0]   req1_seed,
    input  logic [ROUNDS_W-1:0]   req1_rounds,
`ifdef MIX_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [8*WORD_W-1:0]   rsp_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [WORD_W-1:0]   s   [8];
    logic [WORD_W-1:0]   nxt [8];
    logic [ROUNDS_W-1:0] cnt;
    logic                ptr;
    logic                id_q;

    logic                grant_id;
    logic                accept;
    logic                abort_w;
    logic [8*WORD_W-1:0] seed_sel;
    logic [ROUNDS_W-1:0] rounds_sel;

`ifdef MIX_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // NOTE: blocking assignments here are intentional: each word must see the
    // freshly updated predecessor within the same round.
    always_comb begin
        nxt[0] = s[0] + s[7];
        for (int i = 1; i < 8; i++) begin
            nxt[i] = s[i] + nxt[i-1] + WORD_W'(i);
        end
    end

    // Pointer only matters on contention; a lone requester always wins.
    assign grant_id   = (req0_valid && req1_valid) ? ptr : req1_valid;
    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign seed_sel   = grant_id ? req1_seed   : req0_seed;
    assign rounds_sel = grant_id ? req1_rounds : req0_rounds;

    // NOTE: the state words are reset like any other register so that a
    // reset mid-job clears rsp_data immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
            id_q  <= 1'b0;
            for (int i = 0; i < 8; i++) s[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < 8; i++) s[i] <= seed_sel[i*WORD_W +: WORD_W];
                        cnt   <= rounds_sel;
                        id_q  <= grant_id;
                        ptr   <= ~grant_id;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort_w) begin
                        state <= IDLE;
                    end else begin
                        // A zero-round job spends one idle RUN cycle so latency is max(N,1).
                        if (cnt != '0) begin
                            for (int i = 0; i < 8; i++) s[i] <= nxt[i];
                            cnt <= cnt - ROUNDS_W'(1);
                        end
                        if (cnt == '0 || cnt == ROUNDS_W'(1)) state <= DONE;
                    end
                end
                DONE: begin
                    if (abort_w || rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_id    = id_q;

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < 8; i++) rsp_data[i*WORD_W +: WORD_W] = s[i];
    end

endmodule

// File: tb/tb_mix_round_sched.sv
// Directed bench for mix_round_sched: vector table plus hand-written arbitration, backpressure and reset sequences.
module tb_mix_round_sched;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [255:0] req0_seed, req1_seed;
    logic [7:0]   req0_rounds, req1_rounds;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [255:0] rsp_data;
`ifdef MIX_ABORT_EN
    logic         abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mix_round_sched #(.WORD_W(32), .ROUNDS_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_seed  (req0_seed),
        .req0_rounds(req0_rounds),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_seed  (req1_seed),
        .req1_rounds(req1_rounds),
`ifdef MIX_ABORT_EN
        .abort      (abort),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [255:0] seed;
        logic [7:0]   rounds;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] ramp(input int base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'(base + i);
        return r;
    endfunction

    // Reference round: word i absorbs word (i+7)%8, which for i>0 was already updated.
    function automatic logic [255:0] mix(input logic [255:0] seed, input int n);
        logic [31:0]  w [8];
        logic [255:0] r;
        for (int i = 0; i < 8; i++) w[i] = seed[i*32 +: 32];
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) w[i] = w[i] + w[(i + 7) % 8] + 32'(i);
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = w[i];
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_seed = v.seed; req1_rounds = v.rounds;
        end else begin
            req0_valid = 1'b1; req0_seed = v.seed; req0_rounds = v.rounds;
        end
        #1;
        check({tag, " ready"}, 256'(v.id ? req1_ready : req0_ready), 256'(1));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        while (lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) break;
        end
        check({tag, " latency"}, 256'(lat), 256'(v.lat));
        check({tag, " rsp_id"}, 256'(rsp_id), 256'(v.id));
        check({tag, " rsp_data"}, rsp_data, v.exp);
        @(posedge clk);
        #1;
        check({tag, " valid drop"}, 256'(rsp_valid), 256'(0));
    endtask

    vec_t vecs [6];
    int   g_id [$];
    int   g_cyc [$];
    int   r_id [$];

    initial begin
        vecs[0] = '{1'b0, '0, 8'd1,
                    {32'd28, 32'd21, 32'd15, 32'd10, 32'd6, 32'd3, 32'd1, 32'd0}, 1};
        vecs[1] = '{1'b1, '0, 8'd2,
                    {32'd140, 32'd105, 32'd78, 32'd58, 32'd44, 32'd35, 32'd30, 32'd28}, 2};
        vecs[2] = '{1'b0, ramp(100), 8'd0, ramp(100), 1};
        vecs[3] = '{1'b1, {8{32'hFFFF_FFFF}}, 8'd1,
                    {32'h13, 32'hD, 32'h8, 32'h4, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE}, 1};
        vecs[4] = '{1'b1, ramp(7), 8'd0, ramp(7), 1};
        vecs[5] = '{1'b0, ramp(100), 8'd255, mix(ramp(100), 255), 255};

        rsp_ready   = 1'b1;
        req0_seed   = '0; req1_seed   = '0;
        req0_rounds = '0; req1_rounds = '0;
`ifdef MIX_ABORT_EN
        abort = 1'b0;
`endif
        do_reset();

        #1;
        check("reset rsp_valid", 256'(rsp_valid), 256'(0));
        check("reset rsp_id", 256'(rsp_id), 256'(0));
        check("reset rsp_data", rsp_data, '0);

        // Contention from reset: grants must alternate 0,1,0,1 every 3 cycles.
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_rounds = 8'd1; req1_rounds = 8'd1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); end
            if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); end
            if (rsp_valid && rsp_ready) r_id.push_back(int'(rsp_id));
            @(negedge clk);
        end
        check("rr grant count", 256'(g_id.size()), 256'(4));
        check("rr rsp count", 256'(r_id.size()), 256'(4));
        for (int i = 0; i < 4 && i < g_id.size(); i++) begin
            check($sformatf("rr grant %0d id", i), 256'(g_id[i]), 256'(i % 2));
            check($sformatf("rr grant %0d cycle", i), 256'(g_cyc[i]), 256'(3 * i));
        end
        for (int i = 0; i < 4 && i < r_id.size(); i++)
            check($sformatf("rr rsp %0d id", i), 256'(r_id[i]), 256'(i % 2));
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result must hold for 5 cycles with no acceptance.
        do_reset();
        begin
            int lat;
            lat = 0;
            rsp_ready = 1'b0;
            req0_valid = 1'b1; req0_seed = ramp(3); req0_rounds = 8'd2;
            @(posedge clk);
            #1;
            req0_valid = 1'b0;
            while (lat < 20 && !rsp_valid) begin
                @(posedge clk);
                lat++;
                #1;
            end
            check("hold first valid", 256'(rsp_valid), 256'(1));
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_rounds = 8'd1; req1_rounds = 8'd1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("hold %0d valid", c), 256'(rsp_valid), 256'(1));
                check($sformatf("hold %0d data", c), rsp_data, mix(ramp(3), 2));
                check($sformatf("hold %0d id", c), 256'(rsp_id), 256'(0));
                check($sformatf("hold %0d readies", c), 256'({req0_ready, req1_ready}), 256'(0));
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            check("release valid", 256'(rsp_valid), 256'(0));
            check("release next grant", 256'({req0_ready, req1_ready}), 256'(2'b01));
        end

        // Reset in the middle of a long job clears outputs at once and resets the pointer.
        do_reset();
        req0_valid = 1'b1; req0_seed = ramp(100); req0_rounds = 8'd10;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midjob data busy", 256'(rsp_data != '0), 256'(1));
        rst_n = 1'b0;
        #1;
        check("midrst rsp_valid", 256'(rsp_valid), 256'(0));
        check("midrst rsp_id", 256'(rsp_id), 256'(0));
        check("midrst rsp_data", rsp_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("post rst grant", 256'({req0_ready, req1_ready}), 256'(2'b10));

`ifdef MIX_ABORT_EN
        do_reset();
        req0_valid = 1'b1; req0_seed = ramp(1); req0_rounds = 8'd10;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort rsp_valid", 256'(rsp_valid), 256'(0));
        check("abort idle", 256'(req1_ready), 256'(1));
        req1_valid = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            check("abort no rsp", 256'(seen), 256'(0));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
